// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the logic sweep checker: FSM states, mode
// encoding and the saturating mismatch counter.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_SWEEP  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    localparam int              MM_W   = 16;
    localparam logic [MM_W-1:0] MM_SAT = {MM_W{1'b1}};

    function automatic logic [MM_W-1:0] sat_inc(input logic [MM_W-1:0] v);
        return (v == MM_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sweep_stim_gen.sv
// Stimulus register for the sweep checker: loads a start vector, then steps
// either by binary increment or by flipping one selected bit.
module sweep_stim_gen
    import logic_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [N_IN-1:0] load_val,
    input  logic            step,
    input  logic            mode,
    input  logic [2:0]      tog_sel,
    output logic [N_IN-1:0] stim
);

    logic [N_IN-1:0] stim_q, stim_d;

    always_comb begin
        stim_d = stim_q;
        if (load) begin
            stim_d = load_val;
        end else if (step) begin
            // tog_sel is already range-limited by the caller
            stim_d = (mode == MODE_TOGGLE) ? (stim_q ^ (N_IN'(1) << tog_sel))
                                           : (stim_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stim_q <= '0;
        else        stim_q <= stim_d;
    end

    assign stim = stim_q;

endmodule

// File: rtl/logic_sweep_checker.sv
// Self-checking stimulus sequencer: drives vectors into a combinational DUT,
// samples its response at the end of each hold window and counts mismatches.
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int                    N_IN      = 3,
    parameter int                    HOLD      = 20,
    parameter int                    TOG_COUNT = 8,
    parameter logic [(1<<N_IN)-1:0]  EXPECT    = 8'hE8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [N_IN-1:0] base,
    input  logic [2:0]      tog_sel,
    input  logic            dut_f,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            sample_valid,
    output logic [7:0]      sample_idx,
    output logic            sample_err,
    output logic [MM_W-1:0] mismatch_cnt,
    output logic            done,
    output logic            pass
);

    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int IW    = 16;
    localparam int N_VEC = 1 << N_IN;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [2:0]      tog_sel_q, tog_sel_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            busy_q, busy_d;
    logic            sample_valid_q, sample_valid_d;
    logic [7:0]      sample_idx_q, sample_idx_d;
    logic            sample_err_q, sample_err_d;
    logic [MM_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            stim_load, stim_step;
    logic [N_IN-1:0] stim_load_val;
    logic            last_vec, mis;

    sweep_stim_gen #(.N_IN(N_IN)) u_stim (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (stim_load),
        .load_val (stim_load_val),
        .step     (stim_step),
        .mode     (mode_q),
        .tog_sel  (tog_sel_q),
        .stim     (stim)
    );

    assign last_vec = (mode_q == MODE_TOGGLE) ? (idx_q == IW'(TOG_COUNT - 1))
                                              : (idx_q == IW'(N_VEC - 1));
    assign mis      = (dut_f != EXPECT[stim]);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        tog_sel_d      = tog_sel_q;
        idx_d          = idx_q;
        hold_cnt_d     = hold_cnt_q;
        busy_d         = busy_q;
        sample_valid_d = 1'b0;
        sample_idx_d   = sample_idx_q;
        sample_err_d   = sample_err_q;
        mismatch_cnt_d = mismatch_cnt_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        stim_load      = 1'b0;
        stim_step      = 1'b0;
        stim_load_val  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d         = mode;
                    tog_sel_d      = (int'(tog_sel) < N_IN) ? tog_sel : 3'd0;
                    stim_load      = 1'b1;
                    stim_load_val  = (mode == MODE_TOGGLE) ? base : '0;
                    mismatch_cnt_d = '0;
                    pass_d         = 1'b0;
                    idx_d          = '0;
                    hold_cnt_d     = '0;
                    busy_d         = 1'b1;
                    state_d        = APPLY;
                end
            end
            APPLY: begin
                if (hold_cnt_q == HW'(HOLD - 1)) begin
                    sample_valid_d = 1'b1;
                    sample_idx_d   = idx_q[7:0];
                    sample_err_d   = mis;
                    if (mis) mismatch_cnt_d = sat_inc(mismatch_cnt_q);
                    if (last_vec) begin
                        state_d = DONE;
                    end else begin
                        stim_step  = 1'b1;
                        idx_d      = idx_q + 1'b1;
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            DONE: begin
                // start is deliberately not looked at here
                done_d  = 1'b1;
                pass_d  = (mismatch_cnt_q == '0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= MODE_SWEEP;
            tog_sel_q      <= '0;
            idx_q          <= '0;
            hold_cnt_q     <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_err_q   <= 1'b0;
            mismatch_cnt_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            tog_sel_q      <= tog_sel_d;
            idx_q          <= idx_d;
            hold_cnt_q     <= hold_cnt_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            sample_err_q   <= sample_err_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
        end
    end

    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign sample_err   = sample_err_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign done         = done_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: two instances (HOLD=20 and HOLD=1) exercised
// with directed and random runs against a vector-list reference model.
module tb_logic_sweep_checker;

    localparam int          TOG_B = 5;
    localparam logic [7:0]  EXP_A = 8'hE8;
    localparam logic [7:0]  EXP_B = 8'h96;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       start, mode_i, dut_f;
    logic [1:0][2:0]  base_i, tsel_i, stim_o;
    logic [1:0][7:0]  tbl, idx_o;
    logic [1:0][15:0] cnt_o;
    logic [1:0]       busy_o, sv_o, err_o, done_o, pass_o;

    assign dut_f[0] = tbl[0][stim_o[0]];
    assign dut_f[1] = tbl[1][stim_o[1]];

    logic_sweep_checker #(.N_IN(3), .HOLD(20), .TOG_COUNT(8), .EXPECT(EXP_A)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode_i[0]), .base(base_i[0]),
        .tog_sel(tsel_i[0]), .dut_f(dut_f[0]), .stim(stim_o[0]), .busy(busy_o[0]),
        .sample_valid(sv_o[0]), .sample_idx(idx_o[0]), .sample_err(err_o[0]),
        .mismatch_cnt(cnt_o[0]), .done(done_o[0]), .pass(pass_o[0])
    );

    logic_sweep_checker #(.N_IN(3), .HOLD(1), .TOG_COUNT(TOG_B), .EXPECT(EXP_B)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode_i[1]), .base(base_i[1]),
        .tog_sel(tsel_i[1]), .dut_f(dut_f[1]), .stim(stim_o[1]), .busy(busy_o[1]),
        .sample_valid(sv_o[1]), .sample_idx(idx_o[1]), .sample_err(err_o[1]),
        .mismatch_cnt(cnt_o[1]), .done(done_o[1]), .pass(pass_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One full run on instance sel; the model is the list of vectors the rules
    // imply plus the truth-table lookup of each one.
    task automatic run(input int sel, input logic md, input logic [2:0] bs,
                       input logic [2:0] ts, input logic [7:0] dtbl, input int restart_edge);
        int         h    = (sel == 1) ? 1 : 20;
        int         v    = (md == 1'b1) ? ((sel == 1) ? TOG_B : 8) : 8;
        logic [7:0] ex   = (sel == 1) ? EXP_B : EXP_A;
        int         tbit = (ts < 3'd3) ? int'(ts) : 0;
        logic [2:0] vec[$];
        bit         bad[$];
        int         errs = 0;
        int         run_cnt = 0;
        logic [2:0] cur;
        for (int k = 0; k < v; k++) begin
            if (md) cur = (k % 2 == 1) ? (bs ^ (3'b001 << tbit)) : bs;
            else    cur = 3'(k);
            vec.push_back(cur);
            bad.push_back(dtbl[cur] != ex[cur]);
            if (dtbl[cur] != ex[cur]) errs++;
        end

        tbl[sel]    = dtbl;
        mode_i[sel] = md;
        base_i[sel] = bs;
        tsel_i[sel] = ts;
        start[sel]  = 1'b1;
        @(posedge clk); #1;
        start[sel]  = 1'b0;
        // scramble the inputs to make sure they were captured, not followed
        mode_i[sel] = ~md;
        base_i[sel] = ~bs;
        tsel_i[sel] = 3'($urandom_range(0, 7));
        chk($sformatf("i%0d busy_e0", sel), 32'(busy_o[sel]), 32'd1);
        chk($sformatf("i%0d stim_e0", sel), 32'(stim_o[sel]), 32'(vec[0]));
        chk($sformatf("i%0d pass_e0", sel), 32'(pass_o[sel]), 32'd0);

        for (int e = 1; e <= v * h + 3; e++) begin
            logic       exp_sv;
            int         k;
            if (e == restart_edge) begin
                start[sel]  = 1'b1;
                mode_i[sel] = ~md;
                base_i[sel] = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            start[sel] = 1'b0;
            exp_sv = (e % h == 0) && (e / h <= v);
            k      = e / h - 1;
            chk($sformatf("i%0d sv_e%0d", sel, e), 32'(sv_o[sel]), 32'(exp_sv));
            if (exp_sv) begin
                chk($sformatf("i%0d idx_e%0d", sel, e), 32'(idx_o[sel]), 32'(k));
                chk($sformatf("i%0d err_e%0d", sel, e), 32'(err_o[sel]), 32'(bad[k]));
                if (bad[k]) run_cnt++;
            end
            if (e % h == 0 && e / h < v)
                chk($sformatf("i%0d stim_e%0d", sel, e), 32'(stim_o[sel]), 32'(vec[e / h]));
            else if (e >= v * h)
                chk($sformatf("i%0d stim_hold_e%0d", sel, e), 32'(stim_o[sel]), 32'(vec[v - 1]));
            chk($sformatf("i%0d cnt_e%0d", sel, e), 32'(cnt_o[sel]), 32'(run_cnt));
            chk($sformatf("i%0d done_e%0d", sel, e), 32'(done_o[sel]), 32'(e == v * h + 1));
            chk($sformatf("i%0d busy_e%0d", sel, e), 32'(busy_o[sel]), 32'(e <= v * h));
            chk($sformatf("i%0d pass_e%0d", sel, e), 32'(pass_o[sel]),
                32'((e > v * h) && (errs == 0)));
        end
        chk($sformatf("i%0d total_errs", sel), 32'(cnt_o[sel]), 32'(errs));
    endtask

    task automatic run_reset();
        bit saw_done = 0;
        tbl[0]    = 8'hFF;
        mode_i[0] = 1'b0;
        base_i[0] = 3'd0;
        tsel_i[0] = 3'd0;
        start[0]  = 1'b1;
        @(posedge clk); #1;
        start[0]  = 1'b0;
        repeat (70) @(posedge clk);
        #2;
        // vectors 0,1,2 sampled against stuck-at-1: all three disagree with E8
        chk("rst pre_cnt", 32'(cnt_o[0]), 32'd3);
        chk("rst pre_stim", 32'(stim_o[0]), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst stim", 32'(stim_o[0]), 32'd0);
        chk("rst busy", 32'(busy_o[0]), 32'd0);
        chk("rst cnt", 32'(cnt_o[0]), 32'd0);
        chk("rst pass", 32'(pass_o[0]), 32'd0);
        chk("rst sv", 32'(sv_o[0]), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done_o[0] || busy_o[0]) saw_done = 1;
        end
        chk("rst no_done", 32'(saw_done), 32'd0);
        chk("rst pass_after", 32'(pass_o[0]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        start  = '0;
        mode_i = '0;
        base_i = '0;
        tsel_i = '0;
        tbl    = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("i%0d reset_stim", s), 32'(stim_o[s]), 32'd0);
            chk($sformatf("i%0d reset_busy", s), 32'(busy_o[s]), 32'd0);
            chk($sformatf("i%0d reset_sv", s), 32'(sv_o[s]), 32'd0);
            chk($sformatf("i%0d reset_idx", s), 32'(idx_o[s]), 32'd0);
            chk($sformatf("i%0d reset_err", s), 32'(err_o[s]), 32'd0);
            chk($sformatf("i%0d reset_cnt", s), 32'(cnt_o[s]), 32'd0);
            chk($sformatf("i%0d reset_done", s), 32'(done_o[s]), 32'd0);
            chk($sformatf("i%0d reset_pass", s), 32'(pass_o[s]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 1'b0, 3'd0,     3'd0, 8'hE8, -1);   // majority DUT, clean sweep
        run(0, 1'b0, 3'd0,     3'd0, 8'h00, -1);   // stuck-at-0: 4 mismatches
        run(0, 1'b1, 3'b101,   3'd1, 8'hE8, -1);   // toggle 101/111
        run(0, 1'b1, 3'b110,   3'd5, 8'hE8, 50);   // restart ignored, tog_sel>=N_IN
        run(0, 1'b1, 3'b010,   3'd0, 8'h00, 161);  // start during DONE ignored
        run_reset();
        run(0, 1'b0, 3'd0,     3'd0, 8'hE8, -1);   // clean sweep after reset
        run(1, 1'b0, 3'd0,     3'd0, EXP_B, -1);   // HOLD=1 back-to-back
        run(1, 1'b1, 3'b011,   3'd2, 8'h00, -1);

        for (int r = 0; r < 10; r++) begin
            int         s   = int'($urandom_range(0, 1));
            logic [7:0] ex  = (s == 1) ? EXP_B : EXP_A;
            logic [7:0] dt  = ($urandom_range(0, 1) == 1) ? ex : 8'($urandom);
            run(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), dt, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_sweep_checker.md
# logic_sweep_checker

Parametrised, self-checking stimulus sequencer for the combinational exercise blocks. It drives an N-input vector into a device under test and holds each vector for a programmable number of cycles. At the end of each hold window it samples the single-bit response and compares it against a truth-table parameter. It supports a full binary sweep and a single-bit toggle sweep, counts mismatches, and reports pass/fail, replacing hand-written per-exercise stimulus sequences.

## Interface
Parameters:
- N_IN, 3: number of DUT inputs; legal range 2..8.
- HOLD, 20: clock cycles each vector is held; must be at least 1.
- TOG_COUNT, 8: number of vectors applied in toggle mode; must be at least 1.
- EXPECT, 8'hE8: expected truth table, 2**N_IN bits; bit i is the expected F for stim == i.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: starts a run; sampled only in IDLE.
- mode, input, 1: 0 selects binary sweep, 1 selects toggle sweep; captured at start.
- base, input, N_IN: first vector in toggle mode; captured at start.
- tog_sel, input, 3: index of the bit flipped in toggle mode; captured at start.
- dut_f, input, 1: DUT response.
- stim, output, N_IN: vector driven to the DUT.
- busy, output, 1: high while a run is in progress.
- sample_valid, output, 1: one-cycle pulse marking a comparison.
- sample_idx, output, 8: index of the vector just compared.
- sample_err, output, 1: mismatch flag for that comparison; valid while sample_valid is high.
- mismatch_cnt, output, 16: saturating mismatch count for the current or last run.
- done, output, 1: one-cycle pulse at the end of a run.
- pass, output, 1: mismatch_cnt == 0 for the last completed run; held until the next start.

## Operation
- States: IDLE, APPLY, DONE.
- Reset values: every output is 0, and the state is IDLE.
- IDLE with start = 1:
  - Capture mode, base and tog_sel.
  - Load stim with 0 in sweep mode, or with base in toggle mode.
  - Clear mismatch_cnt, pass, the vector index and the hold counter.
  - Set busy and go to APPLY.
- APPLY:
  - hold_cnt counts 0..HOLD-1.
  - On the edge where hold_cnt == HOLD-1, sample dut_f and compare it with EXPECT[stim].
  - On that edge, pulse sample_valid and load sample_idx and sample_err.
  - On a mismatch, increment mismatch_cnt; it saturates at 16'hFFFF.
  - If this was the last vector, go to DONE. Otherwise advance stim and the index, and clear hold_cnt.
- Vector advance:
  - Sweep mode: stim + 1. The run covers 2**N_IN vectors, so stim never wraps during a run.
  - Toggle mode: stim ^ (1 << tog_sel). The run covers TOG_COUNT vectors. A tog_sel value >= N_IN is treated as 0.
- DONE (one cycle): pulse done, set pass = (mismatch_cnt == 0), clear busy, return to IDLE.
- stim holds its final vector in IDLE.
- start is ignored while busy, including in the DONE cycle.
- An rst_n assertion mid-run aborts immediately to the reset values. No done pulse is produced and pass stays 0.

## Timing
- Edge 0: start is sampled. stim holds vector 0 after edge 0.
- Vector k is applied after edge k*HOLD and sampled at edge (k+1)*HOLD. The next vector is applied on that same edge. sample_valid is high for the cycle after that edge.
- Let V be the vector count. The last sample is taken at edge V*HOLD. done and pass update at edge V*HOLD+1, when busy falls.
- HOLD = 1 gives back-to-back samples: sample_valid stays high for V consecutive cycles.
- The earliest accepted restart is the cycle after done.
- dut_f must be settled within HOLD cycles; the block adds no synchroniser.

## Structure
- Package logic_sweep_pkg holds:
  - the state enum (IDLE, APPLY, DONE);
  - the mode encoding (MODE_SWEEP = 0, MODE_TOGGLE = 1);
  - the mismatch counter width (16) and saturation constant.
- Sub-module sweep_stim_gen holds the stim register and the advance logic (sweep increment or toggle XOR), controlled by load and step strobes from the top FSM. The comparator, counters and FSM stay in the top level.

## Test plan
- Sweep, EXPECT = 8'hE8, DUT = 3-input majority model, HOLD = 20 -> 8 sample_valid pulses, stim = 0..7, sample_err always 0, done at edge 161, mismatch_cnt = 0, pass = 1.
- Sweep, same EXPECT, DUT stuck at 0 -> sample_err on indices 3, 5, 6, 7, mismatch_cnt = 4, pass = 0.
- Toggle, base = 3'b101, tog_sel = 1, TOG_COUNT = 8, majority DUT -> stim alternates 101/111, every dut_f is 1, mismatch_cnt = 0, pass = 1, done at edge 161.
- start pulsed at edge 50 of a run, plus tog_sel = 5 with N_IN = 3 in toggle mode -> the second start has no effect. The toggle run flips bit 0, so stim alternates base / base^1.
- rst_n pulsed low at edge 70 of a sweep -> stim, busy, mismatch_cnt and pass go to 0 asynchronously with no done pulse. A new start after release runs a clean sweep.
- HOLD = 1, sweep -> sample_valid high for 8 consecutive cycles and done at edge 9.
